// File: rtl/hi_lo_unit_if.sv
// Decode/ALU-facing bundle of the HI/LO stage: op issue, MT/MF requests,
// architectural HI/LO and the interlock status back to decode.
interface hi_lo_unit_if;
  logic        op_valid;
  logic [2:0]  op;
  logic [63:0] ALU_MULTorDIV_result;
  logic [31:0] divisor;
  logic [31:0] mtx_data;
  logic        read_hi;
  logic        read_lo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        div_zero;

  modport master (
    output op_valid, op, ALU_MULTorDIV_result, divisor, mtx_data, read_hi, read_lo,
    input  hi, lo, busy, stall, div_zero
  );

  modport slave (
    input  op_valid, op, ALU_MULTorDIV_result, divisor, mtx_data, read_hi, read_lo,
    output hi, lo, busy, stall, div_zero
  );
endinterface

// File: rtl/hi_lo_unit.sv
// HI/LO register stage behind the ALU MULT/DIV result. Define HILO_LATENCY_EN for the
// multi-cycle pending buffer with decode interlock; otherwise MULT/DIV commit at issue.
module hi_lo_unit #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 12
) (
  input  logic        clk,
  input  logic        reset,
  hi_lo_unit_if.slave bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  // Operation decode; signed/unsigned variants are indistinguishable here.
  logic is_mul_c;
  logic is_div_c;
  logic is_mthi_c;
  logic is_mtlo_c;
  logic div_ok_c;
  logic req_c;

  always_comb begin
    is_mul_c  = bus.op_valid & ((bus.op == OP_MULT) | (bus.op == OP_MULTU));
    is_div_c  = bus.op_valid & ((bus.op == OP_DIV)  | (bus.op == OP_DIVU));
    is_mthi_c = bus.op_valid & (bus.op == OP_MTHI);
    is_mtlo_c = bus.op_valid & (bus.op == OP_MTLO);
    div_ok_c  = (bus.divisor != '0);
    req_c     = is_mul_c | is_div_c | is_mthi_c | is_mtlo_c;
  end

  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              div_zero_q, div_zero_d;

`ifdef HILO_LATENCY_EN

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] pend_hi_q, pend_hi_d;
  logic [DATA_W-1:0] pend_lo_q, pend_lo_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pend_hi_q  <= '0;
      pend_lo_q  <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_hi_q  <= pend_hi_d;
      pend_lo_q  <= pend_lo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  // Next state: accept ops only in IDLE; in BUSY count down, then commit pending to HI/LO.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_hi_d  = pend_hi_q;
    pend_lo_d  = pend_lo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (is_mul_c) begin
          pend_hi_d = bus.ALU_MULTorDIV_result[63:32];
          pend_lo_d = bus.ALU_MULTorDIV_result[31:0];
          cnt_d     = MULT_LOAD;
          state_d   = ST_BUSY;
        end else if (is_div_c) begin
          if (div_ok_c) begin
            pend_hi_d = bus.ALU_MULTorDIV_result[31:0];
            pend_lo_d = bus.ALU_MULTorDIV_result[63:32];
            cnt_d     = DIV_LOAD;
            state_d   = ST_BUSY;
          end else begin
            div_zero_d = 1'b1;
          end
        end else if (is_mthi_c) begin
          hi_d = bus.mtx_data;
        end else if (is_mtlo_c) begin
          lo_d = bus.mtx_data;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy  = (state_q == ST_BUSY);
  assign bus.stall = (state_q == ST_BUSY) & (bus.read_hi | bus.read_lo | req_c);

`else

  // Latency parameters and MF requests have no effect without the pending path.
  localparam bit unused_cfg = (MULT_CYCLES + DIV_CYCLES) != 0;
  logic unused_rd;
  assign unused_rd = bus.read_hi | bus.read_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  // MULT/DIV land in HI/LO at the issue edge with the same word mapping.
  always_comb begin
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = 1'b0;

    if (is_mul_c) begin
      hi_d = bus.ALU_MULTorDIV_result[63:32];
      lo_d = bus.ALU_MULTorDIV_result[31:0];
    end else if (is_div_c) begin
      if (div_ok_c) begin
        hi_d = bus.ALU_MULTorDIV_result[31:0];
        lo_d = bus.ALU_MULTorDIV_result[63:32];
      end else begin
        div_zero_d = 1'b1;
      end
    end else if (is_mthi_c) begin
      hi_d = bus.mtx_data;
    end else if (is_mtlo_c) begin
      lo_d = bus.mtx_data;
    end
  end

  assign bus.busy  = 1'b0;
  assign bus.stall = 1'b0;

`endif

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_hi_lo_unit.sv
// Self-checking bench for hi_lo_unit: directed scenarios plus random traffic against a
// timeline model (absolute commit-edge bookkeeping), valid with or without HILO_LATENCY_EN.
module tb_hi_lo_unit;
  localparam int unsigned MULT_CYC = 4;
  localparam int unsigned DIV_CYC  = 12;
`ifdef HILO_LATENCY_EN
  localparam bit LAT_EN = 1'b1;
`else
  localparam bit LAT_EN = 1'b0;
`endif

  localparam logic [2:0] NONE = 3'd0;
  localparam logic [2:0] MULT = 3'd1;
  localparam logic [2:0] DIV  = 3'd3;
  localparam logic [2:0] MTHI = 3'd5;
  localparam logic [2:0] MTLO = 3'd6;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hi_lo_unit_if bus ();

  hi_lo_unit #(
    .MULT_CYCLES(MULT_CYC),
    .DIV_CYCLES (DIV_CYC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk;
  int n_pass;

  // Reference model: committed regs plus at most one in-flight result tagged with its commit edge.
  logic [31:0] m_hi, m_lo;
  logic        m_dz;
  logic        p_valid;
  logic [31:0] p_hi, p_lo;
  int unsigned p_edge;
  int unsigned edge_no;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_no);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    p_valid = 1'b0; p_hi = '0; p_lo = '0; p_edge = 0;
  endtask

  task automatic model_edge(input bit v, input logic [2:0] o, input logic [63:0] r,
                            input logic [31:0] d, input logic [31:0] m);
    logic [31:0] nh, nl;
    int unsigned lat;
    bit issue;
    issue = 1'b0;
    nh = '0; nl = '0; lat = 0;
    m_dz = 1'b0;
    if (p_valid) begin
      if (edge_no == p_edge) begin
        m_hi = p_hi; m_lo = p_lo; p_valid = 1'b0;
      end
    end else if (v) begin
      if (o == 3'd1 || o == 3'd2) begin
        nh = r[63:32]; nl = r[31:0]; lat = MULT_CYC; issue = 1'b1;
      end else if (o == 3'd3 || o == 3'd4) begin
        if (d == 0) m_dz = 1'b1;
        else begin nh = r[31:0]; nl = r[63:32]; lat = DIV_CYC; issue = 1'b1; end
      end else if (o == 3'd5) m_hi = m;
      else if (o == 3'd6) m_lo = m;
    end
    if (issue) begin
      if (LAT_EN) begin
        p_valid = 1'b1; p_hi = nh; p_lo = nl; p_edge = edge_no + lat;
      end else begin
        m_hi = nh; m_lo = nl;
      end
    end
    edge_no++;
  endtask

  // One cycle: drive at the falling edge, check outputs, then advance the model over the rising edge.
  task automatic step(input bit v, input logic [2:0] o, input logic [63:0] r, input logic [31:0] d,
                      input logic [31:0] m, input bit rh, input bit rl);
    bit exp_stall;
    @(negedge clk);
    bus.op_valid = v; bus.op = o; bus.ALU_MULTorDIV_result = r;
    bus.divisor = d; bus.mtx_data = m; bus.read_hi = rh; bus.read_lo = rl;
    #1;
    exp_stall = p_valid & (rh | rl | (v & (o >= 3'd1) & (o <= 3'd6)));
    check("hi",       64'(bus.hi),       64'(m_hi));
    check("lo",       64'(bus.lo),       64'(m_lo));
    check("busy",     64'(bus.busy),     64'(p_valid));
    check("stall",    64'(bus.stall),    64'(exp_stall));
    check("div_zero", 64'(bus.div_zero), 64'(m_dz));
    model_edge(v, o, r, d, m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, NONE, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.op_valid = 1'b0; bus.op = NONE; bus.read_hi = 1'b0; bus.read_lo = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_hi",   64'(bus.hi),       64'd0);
    check("rst_lo",   64'(bus.lo),       64'd0);
    check("rst_busy", 64'(bus.busy),     64'd0);
    check("rst_dz",   64'(bus.div_zero), 64'd0);
    #1 reset = 1'b0;
    model_reset();
    model_edge(1'b0, NONE, '0, '0, '0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; edge_no = 0;
    model_reset();
    reset = 1'b1;
    bus.op_valid = 1'b0; bus.op = NONE; bus.ALU_MULTorDIV_result = '0;
    bus.divisor = '0; bus.mtx_data = '0; bus.read_hi = 1'b0; bus.read_lo = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_edge(1'b0, NONE, '0, '0, '0);

    // MTHI in IDLE, one-edge latency.
    step(1'b1, MTHI, '0, '0, 32'hDEADBEEF, 1'b0, 1'b0);
    idle(1);
    check("mthi_val", 64'(bus.hi), 64'h0000_0000_DEAD_BEEF);

    // MULT: hi holds DEADBEEF until the commit edge.
    step(1'b1, MULT, 64'h00000001_00000000, 32'd5, '0, 1'b0, 1'b0);
    idle(5);
    check("mult_hi", 64'(bus.hi), 64'd1);
    check("mult_lo", 64'(bus.lo), 64'd0);

    // DIV 7/2: quotient to LO, remainder to HI.
    step(1'b1, DIV, 64'h00000003_00000001, 32'd2, '0, 1'b0, 1'b0);
    idle(DIV_CYC + 1);
    check("div_lo", 64'(bus.lo), 64'd3);
    check("div_hi", 64'(bus.hi), 64'd1);

    // MFHI held by decode during a MULT.
    step(1'b1, MULT, 64'hAAAA5555_12345678, 32'd1, '0, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 6; i++) step(1'b0, NONE, '0, '0, '0, 1'b1, 1'b0);
    check("mfhi_val", 64'(bus.hi), 64'hAAAA5555);

    // Divide by zero leaves HI/LO alone and pulses div_zero once.
    step(1'b1, MTHI, '0, '0, 32'h11111111, 1'b0, 1'b0);
    step(1'b1, MTLO, '0, '0, 32'h22222222, 1'b0, 1'b0);
    step(1'b1, DIV, 64'hFFFFFFFF_FFFFFFFF, 32'd0, '0, 1'b0, 1'b0);
    check("dz_pulse", 64'(bus.div_zero), 64'd0);
    idle(2);
    check("dz_hi", 64'(bus.hi), 64'h11111111);
    check("dz_lo", 64'(bus.lo), 64'h22222222);

    // MTLO re-presented during a MULT, applied after the commit.
    step(1'b1, MULT, 64'h0BADF00D_CAFEF00D, 32'd1, '0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, MTLO, '0, '0, 32'h5, 1'b0, 1'b0);
    idle(1);
    check("mtlo_lo", 64'(bus.lo), 64'h5);
    check("mtlo_hi", 64'(bus.hi), 64'h0BADF00D);

    // Reset during an in-flight DIV: no later commit.
    step(1'b1, DIV, 64'h12345678_9ABCDEF0, 32'd3, '0, 1'b0, 1'b0);
    idle(4);
    do_reset();
    idle(DIV_CYC + 2);
    check("post_rst_hi", 64'(bus.hi), 64'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] r;
      logic [31:0] d;
      r = {$urandom, $urandom};
      d = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(1'($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), r, d, $urandom,
                1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
